// File: rtl/module_ofm_accum_act.sv
// Output-feature-map accumulator: sums per-pixel partial sums over several
// input-channel-group passes in a local buffer, then applies optional leaky
// activation, rounding requantization and output saturation on the last pass.
module module_ofm_accum_act #(
  parameter int PIX_DEPTH = 256,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [8:0]              cfg_pix_num,
  input  logic [7:0]              cfg_grp_num,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_leaky,
  input  logic                    in_valid,
  input  logic signed [17:0]      in_ch1,
  input  logic signed [17:0]      in_ch2,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_ch1,
  output logic signed [OUT_W-1:0] out_ch2,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = (PIX_DEPTH > 1) ? $clog2(PIX_DEPTH) : 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [ACC_W:0]   O_MAX   = (ACC_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0]   O_MIN   = ~O_MAX;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Signed add clamped to the accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  // Leaky activation, round-half-up right shift, clamp to output range.
  function automatic logic signed [OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] x,
                                                        input logic [4:0] sh,
                                                        input logic lk);
    logic signed [ACC_W:0] y;
    logic signed [ACC_W:0] rnd;
    y   = {x[ACC_W-1], x};
    rnd = '0;
    if (lk && x[ACC_W-1]) y = y >>> 3;
    if (sh != 5'd0) begin
      rnd = (ACC_W+1)'(1) << (sh - 5'd1);
      y   = (y + rnd) >>> sh;
    end
    if (y > O_MAX) return O_MAX[OUT_W-1:0];
    if (y < O_MIN) return O_MIN[OUT_W-1:0];
    return y[OUT_W-1:0];
  endfunction

  state_t                   state_q, state_d;
  logic [8:0]               p_q, p_d, pix_q, pix_d;
  logic [7:0]               g_q, g_d, grp_q, grp_d;
  logic [4:0]               shift_q, shift_d;
  logic                     leaky_q, leaky_d;
  logic                     done_q, done_d;
  logic                     accept;

  logic                     s1_v_q, s1_first_q, s1_last_q;
  logic [AW-1:0]            s1_addr_q;
  logic signed [ACC_W-1:0]  s1_in_q [2];
  logic                     s2_v_q, s2_first_q, s2_last_q;
  logic [AW-1:0]            s2_addr_q;
  logic signed [ACC_W-1:0]  s2_in_q [2];
  logic signed [ACC_W-1:0]  s2_old_q [2];
  logic signed [ACC_W-1:0]  s2_old_d [2];
  logic signed [ACC_W-1:0]  s2_sum [2];
  logic                     s3_v_q, s3_last_q;
  logic [AW-1:0]            s3_addr_q;
  logic signed [ACC_W-1:0]  s3_sum_q [2];
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_q [2];
  logic signed [OUT_W-1:0]  out_d [2];
  logic [2*ACC_W-1:0]       mem [PIX_DEPTH];
  logic [2*ACC_W-1:0]       rd_word;

  assign accept    = (state_q == RUN) && in_valid;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_ch1   = out_q[0];
  assign out_ch2   = out_q[1];

  // Tile control: config latch, pixel/group counters, state transitions.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    p_d     = p_q;
    g_d     = g_q;
    pix_d   = pix_q;
    grp_d   = grp_q;
    shift_d = shift_q;
    leaky_d = leaky_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        pix_d   = cfg_pix_num;
        grp_d   = cfg_grp_num;
        shift_d = cfg_shift;
        leaky_d = cfg_leaky;
        p_d     = '0;
        g_d     = '0;
        state_d = RUN;
      end
      RUN: if (in_valid) begin
        if (p_q == pix_q - 9'd1) begin
          p_d = '0;
          if (g_q == grp_q - 8'd1) state_d = FLUSH;
          else                     g_d     = g_q + 8'd1;
        end else begin
          p_d = p_q + 9'd1;
        end
      end
      FLUSH: if (out_valid_q && !s1_v_q && !s2_v_q && !s3_v_q) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // S2 add, S1 read with forwarding from younger in-flight sums, S3 emit.
  always_comb begin
    rd_word = mem[s1_addr_q];
    for (int c = 0; c < 2; c++) begin
      s2_sum[c] = s2_first_q ? s2_in_q[c] : sat_add(s2_old_q[c], s2_in_q[c]);
      if (s2_v_q && (s2_addr_q == s1_addr_q))      s2_old_d[c] = s2_sum[c];
      else if (s3_v_q && (s3_addr_q == s1_addr_q)) s2_old_d[c] = s3_sum_q[c];
      else                                         s2_old_d[c] = $signed(rd_word[c*ACC_W +: ACC_W]);
    end
    out_valid_d = s3_v_q && s3_last_q;
    for (int c = 0; c < 2; c++) begin
      out_d[c] = out_valid_d ? post_proc(s3_sum_q[c], shift_q, leaky_q) : out_q[c];
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      g_q     <= '0;
      pix_q   <= '0;
      grp_q   <= '0;
      shift_q <= '0;
      leaky_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      g_q     <= g_d;
      pix_q   <= pix_d;
      grp_q   <= grp_d;
      shift_q <= shift_d;
      leaky_q <= leaky_d;
      done_q  <= done_d;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0; s1_addr_q <= '0;
      s2_v_q <= 1'b0; s2_first_q <= 1'b0; s2_last_q <= 1'b0; s2_addr_q <= '0;
      s3_v_q <= 1'b0; s3_last_q  <= 1'b0; s3_addr_q <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        s1_in_q[c] <= '0; s2_in_q[c] <= '0; s2_old_q[c] <= '0;
        s3_sum_q[c] <= '0; out_q[c] <= '0;
      end
    end else begin
      s1_v_q     <= accept;
      s1_first_q <= (g_q == 8'd0);
      s1_last_q  <= (g_q == grp_q - 8'd1);
      s1_addr_q  <= p_q[AW-1:0];
      s1_in_q[0] <= ACC_W'(in_ch1);
      s1_in_q[1] <= ACC_W'(in_ch2);
      s2_v_q     <= s1_v_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_addr_q  <= s1_addr_q;
      s2_in_q    <= s1_in_q;
      s2_old_q   <= s2_old_d;
      s3_v_q     <= s2_v_q;
      s3_last_q  <= s2_last_q;
      s3_addr_q  <= s2_addr_q;
      s3_sum_q   <= s2_sum;
      out_valid_q <= out_valid_d;
      out_q      <= out_d;
    end
  end

  // Partial-sum buffer write-back for non-final passes.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is not reset; each address is written in pass 0 before any read uses it.
    if (s3_v_q && !s3_last_q) mem[s3_addr_q] <= {s3_sum_q[1], s3_sum_q[0]};
  end

endmodule
